// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine for a word-addressed data memory, RMW for byte/half stores.
// Define MAU_STATS_EN to add saturating load/store/error counters.
module mem_access_unit #(
  parameter int MEM_WORDS = 256
`ifdef MAU_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
`ifdef MAU_STATS_EN
  , output logic [STAT_W-1:0] stat_loads
  , output logic [STAT_W-1:0] stat_stores
  , output logic [STAT_W-1:0] stat_errs
`endif
);

  typedef enum logic [2:0] {
    IDLE, RD, WR, GAP, RESP
  } state_t;

  state_t      state, next;
  logic        write_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        bad, err_chk;
  logic [31:0] lane, ext, mask, ins, merged;

  always_comb begin
    unique case (req_size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = req_addr[0];
      2'b10:   bad = |req_addr[1:0];
      default: bad = 1'b1;
    endcase
    err_chk = bad || (req_addr[31:2] >= 30'(MEM_WORDS));
  end

  // Lane offset in bits; aligned halves make addr*8 equal addr[1]*16
  always_comb begin
    lane = mem_rdata >> {addr_q[1:0], 3'b000};
    mask = '1;
    ins  = wdata_q;
    ext  = lane;
    unique case (size_q)
      2'b00: begin
        ext  = uns_q ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
        mask = 32'h0000_00ff << {addr_q[1:0], 3'b000};
        ins  = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        ext  = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
        mask = 32'h0000_ffff << {addr_q[1], 4'b0000};
        ins  = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
    merged = (mem_rdata & ~mask) | (ins & mask);
  end

  always_comb begin
    next       = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (err_chk)
            next = RESP;
          else if (!req_write || req_size != 2'b10)
            next = RD;
          else
            next = WR;
        end
      end
      RD: begin
        mem_read = 1'b1;
        next     = write_q ? WR : RESP;
      end
      WR: begin
        mem_write = 1'b1;
        next      = GAP;
      end
      GAP: next = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= next;
      if (state == IDLE && req_valid) begin
        write_q <= req_write;
        uns_q   <= req_unsigned;
        err_q   <= err_chk;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
      end
      if (state == RD) begin
        if (write_q) wdata_q <= merged;
        else         rdata_q <= ext;
      end
    end
  end

  assign busy       = (state != IDLE);
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = wdata_q;
  assign resp_rdata = (state == RESP) ? rdata_q : '0;
  assign resp_err   = (state == RESP) && err_q;

`ifdef MAU_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errs   <= '0;
    end else if (state == RESP && resp_ready) begin
      if (err_q) begin
        if (~&stat_errs) stat_errs <= stat_errs + STAT_W'(1);
      end else if (write_q) begin
        if (~&stat_stores) stat_stores <= stat_stores + STAT_W'(1);
      end else begin
        if (~&stat_loads) stat_loads <= stat_loads + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory.
// Checks data, latency, error handling, stall stability and mid-transaction reset.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err, busy;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
`ifdef MAU_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_errs;
`endif

  logic [31:0] mem [256];
  int          rd_cnt = 0, wr_cnt = 0;
  logic        both_hi = 1'b0;
  int          total = 0, bad = 0;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
`ifdef MAU_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores)
    , .stat_errs(stat_errs)
`endif
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_read) rd_cnt <= rd_cnt + 1;
    if (mem_write) begin
      wr_cnt <= wr_cnt + 1;
      mem[mem_addr[9:2]] <= mem_wdata;
    end
    if (mem_read && mem_write) both_hi <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xact(input logic wr, input logic [1:0] sz,
                      input logic un, input logic [31:0] a,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er,
                      output int lat, output int nr, output int nw);
    int r0, w0;
    r0 = rd_cnt;
    w0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_size = sz;
    req_unsigned = un;
    req_addr = a;
    req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("resp_valid_seen", {31'b0, resp_valid}, 32'h1);
    rd = resp_rdata;
    er = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, resp_valid}, 32'h1);
      check("hold_rdata", resp_rdata, rd);
      check("hold_req_ready", {31'b0, req_ready}, 32'h0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("ready_after", {31'b0, req_ready}, 32'h1);
    nr = rd_cnt - r0;
    nw = wr_cnt - w0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, nr, nw;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_mem_rw", {30'b0, mem_read, mem_write}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);

    xact(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, nr, nw);
    check("sw_lat", lat, 3);
    check("sw_err", {31'b0, er}, 0);
    check("sw_rdata", rd, 0);
    check("sw_pulses", nw, 1);
    check("sw_noread", nr, 0);
    check("sw_mem", mem[4], 32'hDEADBEEF);

    xact(0, 2'b10, 0, 32'h10, 0, 0, rd, er, lat, nr, nw);
    check("lw_lat", lat, 2);
    check("lw_data", rd, 32'hDEADBEEF);
    check("lw_err", {31'b0, er}, 0);

    xact(1, 2'b10, 0, 32'h10, 32'h11223344, 0, rd, er, lat, nr, nw);
    xact(1, 2'b00, 0, 32'h11, 32'h123456AA, 0, rd, er, lat, nr, nw);
    check("sb_lat", lat, 4);
    check("sb_pulses", nw, 1);
    check("sb_mem", mem[4], 32'h1122AA44);
    xact(0, 2'b00, 0, 32'h11, 0, 0, rd, er, lat, nr, nw);
    check("lb_signed", rd, 32'hFFFFFFAA);
    xact(0, 2'b00, 1, 32'h11, 0, 0, rd, er, lat, nr, nw);
    check("lb_unsigned", rd, 32'h000000AA);
    xact(0, 2'b00, 0, 32'h13, 0, 0, rd, er, lat, nr, nw);
    check("lb_lane3", rd, 32'h00000011);

    xact(1, 2'b10, 0, 32'h10, 32'h80001234, 0, rd, er, lat, nr, nw);
    xact(0, 2'b01, 1, 32'h12, 0, 0, rd, er, lat, nr, nw);
    check("lh_unsigned", rd, 32'h00008000);
    xact(0, 2'b01, 0, 32'h12, 0, 0, rd, er, lat, nr, nw);
    check("lh_signed", rd, 32'hFFFF8000);
    xact(0, 2'b01, 0, 32'h10, 0, 0, rd, er, lat, nr, nw);
    check("lh_low", rd, 32'h00001234);
    xact(1, 2'b01, 0, 32'h12, 32'h7777BEEF, 0, rd, er, lat, nr, nw);
    check("sh_mem", mem[4], 32'hBEEF1234);

    xact(1, 2'b01, 0, 32'h13, 32'h1, 0, rd, er, lat, nr, nw);
    check("e_half_err", {31'b0, er}, 1);
    check("e_half_lat", lat, 1);
    check("e_half_mem", nr + nw, 0);
    xact(0, 2'b10, 0, 32'h102, 0, 0, rd, er, lat, nr, nw);
    check("e_word_err", {31'b0, er}, 1);
    check("e_word_rdata", rd, 0);
    check("e_word_mem", nr + nw, 0);
    xact(0, 2'b11, 0, 32'h0, 0, 0, rd, er, lat, nr, nw);
    check("e_size_err", {31'b0, er}, 1);
    check("e_size_mem", nr + nw, 0);
    xact(1, 2'b10, 0, 32'h400, 32'h5, 0, rd, er, lat, nr, nw);
    check("e_range_err", {31'b0, er}, 1);
    check("e_range_mem", nr + nw, 0);
    xact(1, 2'b10, 0, 32'h3FC, 32'hA5A5_0FF0, 0, rd, er, lat, nr, nw);
    check("top_store_err", {31'b0, er}, 0);
    xact(0, 2'b10, 0, 32'h3FC, 0, 0, rd, er, lat, nr, nw);
    check("top_load", rd, 32'hA5A5_0FF0);

    xact(0, 2'b10, 0, 32'h10, 0, 5, rd, er, lat, nr, nw);
    check("stall_data", rd, 32'hBEEF1234);
    xact(1, 2'b00, 0, 32'h10, 32'h99, 5, rd, er, lat, nr, nw);
    check("stall_st_pulses", nw, 1);
    check("stall_st_mem", mem[4], 32'hBEEF1299);

    xact(1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 0, rd, er, lat, nr, nw);
    nw = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size = 2'b00;
    req_addr = 32'h21;
    req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_in_rd", {31'b0, mem_read}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_busy", {31'b0, busy}, 32'h0);
    check("mid_rw", {30'b0, mem_read, mem_write}, 32'h0);
    check("mid_ready", {31'b0, req_ready}, 32'h1);
    repeat (4) @(negedge clk);
    check("mid_resp", {31'b0, resp_valid}, 32'h0);
    check("mid_nowrite", wr_cnt - nw, 0);
    check("mid_mem", mem[8], 32'hCAFEF00D);

    check("never_both", {31'b0, both_hi}, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
